// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port, zoom controls and VGA pins of the frame reader.
// master = vga_frame_reader, slave = the RAM/pad side that feeds and observes it.
interface vga_frame_reader_if;
    logic        zoom_on;
    logic [8:0]  zoom_x;
    logic [7:0]  zoom_y;
    logic [16:0] rAddr;
    logic [11:0] rData;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        h_sync;
    logic        v_sync;
    logic        de;
    logic        frame_start;

    modport master (
        input  zoom_on, zoom_x, zoom_y, rData,
        output rAddr, red, green, blue, h_sync, v_sync, de, frame_start
    );

    modport slave (
        output zoom_on, zoom_x, zoom_y, rData,
        input  rAddr, red, green, blue, h_sync, v_sync, de, frame_start
    );
endinterface

// File: rtl/vga_frame_reader.sv
// Purpose: reads the 320x240 RGB444 frame buffer out as 640x480@60 VGA, 2x2 upscale; 4x4 zoom window with VGA_FRAME_READER_ZOOM_EN.
// Latency: rAddr 1 cycle after the counter position, pins (RGB/syncs/de/frame_start) 3 cycles after it.
// Backpressure: none; free-running pixel stream, the RAM read port must answer every cycle.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FB_WIDTH = 320
) (
    input  logic               pclk,
    input  logic               reset_n,
    vga_frame_reader_if.master bus
);
    localparam logic [9:0]  H_LAST     = 10'(H_ACTIVE + 159);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  H_SYNC_BEG = 10'(H_ACTIVE + 16);
    localparam logic [9:0]  H_SYNC_END = 10'(H_ACTIVE + 112);
    localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + 44);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + 10);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + 12);
    localparam logic [16:0] FB_W       = 17'(FB_WIDTH);

    typedef struct packed {
        logic de;
        logic h_sync;
        logic v_sync;
        logic frame_start;
    } meta_t;

    localparam meta_t META_IDLE = '{de: 1'b0, h_sync: 1'b1, v_sync: 1'b1, frame_start: 1'b0};

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [16:0] raddr_q, raddr_d;
    meta_t       meta1_q, meta1_d;
    meta_t       meta2_q, meta2_d;
    meta_t       meta3_q, meta3_d;
    logic [11:0] rgb_q, rgb_d;
    logic        frame_top;
    logic [16:0] addr_norm;
    logic [16:0] addr_sel;

    assign frame_top = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    assign addr_norm = 17'(v_cnt_q >> 1) * FB_W + 17'(h_cnt_q >> 1);

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

`ifdef VGA_FRAME_READER_ZOOM_EN
    logic        zoom_on_q, zoom_on_d;
    logic [8:0]  zoom_x_q, zoom_x_d;
    logic [7:0]  zoom_y_q, zoom_y_d;
    logic [16:0] addr_zoom;

    // The _d values are used directly so pixel (0,0) already sees the freshly latched origin.
    always_comb begin
        zoom_on_d = zoom_on_q;
        zoom_x_d  = zoom_x_q;
        zoom_y_d  = zoom_y_q;
        if (frame_top) begin
            zoom_on_d = bus.zoom_on;
            zoom_x_d  = (bus.zoom_x > 9'd160) ? 9'd160 : bus.zoom_x;
            zoom_y_d  = (bus.zoom_y > 8'd120) ? 8'd120 : bus.zoom_y;
        end
    end

    assign addr_zoom = (17'(zoom_y_d) + 17'(v_cnt_q >> 2)) * FB_W
                     + 17'(zoom_x_d) + 17'(h_cnt_q >> 2);
    assign addr_sel  = zoom_on_d ? addr_zoom : addr_norm;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            zoom_on_q <= 1'b0;
            zoom_x_q  <= '0;
            zoom_y_q  <= '0;
        end else begin
            zoom_on_q <= zoom_on_d;
            zoom_x_q  <= zoom_x_d;
            zoom_y_q  <= zoom_y_d;
        end
    end
`else
    logic zoom_unused;
    assign zoom_unused = ^{bus.zoom_on, bus.zoom_x, bus.zoom_y};
    assign addr_sel    = addr_norm;
`endif

    // Timing flags travel alongside the RAM read so they land with the pixel they describe.
    always_comb begin
        meta1_d             = META_IDLE;
        meta1_d.de          = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        meta1_d.h_sync      = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
        meta1_d.v_sync      = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
        meta1_d.frame_start = frame_top;
        raddr_d             = meta1_d.de ? addr_sel : '0;
        meta2_d             = meta1_q;
        meta3_d             = meta2_q;
        rgb_d               = meta2_q.de ? bus.rData : '0;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            raddr_q <= '0;
            meta1_q <= META_IDLE;
            meta2_q <= META_IDLE;
            meta3_q <= META_IDLE;
            rgb_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            raddr_q <= raddr_d;
            meta1_q <= meta1_d;
            meta2_q <= meta2_d;
            meta3_q <= meta3_d;
            rgb_q   <= rgb_d;
        end
    end

    assign bus.rAddr       = raddr_q;
    assign bus.red         = rgb_q[11:8];
    assign bus.green       = rgb_q[7:4];
    assign bus.blue        = rgb_q[3:0];
    assign bus.de          = meta3_q.de;
    assign bus.h_sync      = meta3_q.h_sync;
    assign bus.v_sync      = meta3_q.v_sync;
    assign bus.frame_start = meta3_q.frame_start;
endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

- Read side of the 320x240 RGB444 camera frame buffer.
- Generates 640x480@60 VGA timing on a 25 MHz pixel clock.
- Addresses the buffer's synchronous read port and drives the VGA pins with pipeline-aligned RGB and syncs.
- Normal mode upscales each stored pixel 2x2; the optional zoom mode shows a 160x120 window 4x4.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- FB_WIDTH, 320, stored pixels per buffer line

Ports:
- pclk  in  1  VGA pixel clock, 25 MHz; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- zoom_on  in  1  request zoom mode; sampled at frame start
- zoom_x  in  9  zoom window origin column, 0..160
- zoom_y  in  8  zoom window origin row, 0..120
- rAddr  out  17  frame-buffer read address; RAM returns rData one cycle later
- rData  in  12  {R[11:8], G[7:4], B[3:0]} from the buffer
- red, green, blue  out  4 each  VGA colour
- h_sync, v_sync  out  1  active-low syncs
- de  out  1  display-enable, aligned with RGB
- frame_start  out  1  one-cycle pulse, aligned with the first active pixel of a frame

## Operation
- Horizontal counter h_cnt runs 0..799:
  - active 0..639
  - front porch 640..655
  - sync 656..751
  - back porch 752..799
- Vertical counter v_cnt runs 0..524. It increments when h_cnt wraps 799->0:
  - active 0..479
  - front porch 480..489
  - sync 490..491
  - back porch 492..524
  - wraps 524->0
- Normal address: rAddr = (v_cnt>>1)*320 + (h_cnt>>1). Range 0..76799 fits 17 bits, no overflow.
- Zoom address: rAddr = (zy + (v_cnt>>2))*320 + (zx + (h_cnt>>2)).
  - zx and zy are the latched origin.
  - Maximum value (120+119)*320 + (160+159) = 76799.
- Origin latch: at h_cnt=0, v_cnt=0 the block latches zoom_on, zoom_x and zoom_y.
  - zoom_x > 160 is clamped to 160.
  - zoom_y > 120 is clamped to 120.
  - Mid-frame changes take effect only at the next frame start, so a frame never tears.
- Outside the active area rAddr = 0.
- RGB outputs are forced to 0 whenever de = 0. rData is ignored there.
- frame_start is asserted for the pixel at h_cnt=0, v_cnt=0 after pipeline delay.

## Timing
- Pipeline, counter cycle t:
  - rAddr registered at t+1
  - rData valid at t+2
  - red/green/blue, h_sync, v_sync, de and frame_start registered at t+3
- All timing outputs are delayed by the same 3 cycles, so pixel (0,0) appears on the same cycle as de rising.
- Reset values:
  - counters 0 and pipeline cleared
  - rAddr = 0, RGB = 0, de = 0, frame_start = 0
  - h_sync = 1, v_sync = 1 (inactive)
  - latched zoom state off, origin 0
- Reset mid-frame: everything returns to reset values asynchronously. After release, counting restarts at (0,0) and the first frame_start appears 3 cycles later.
- h_sync low for exactly 96 cycles per line. v_sync low for exactly 2 lines = 1600 cycles.
- Line period 800 cycles; frame period 420000 cycles.

## Configuration
- Macro VGA_FRAME_READER_ZOOM_EN.
- When defined:
  - The zoom latch, clamp and 4x address path are compiled in.
  - zoom_on selects the mode per frame.
- When undefined:
  - zoom_on, zoom_x and zoom_y remain as ports but are ignored.
  - Only the 2x normal path exists.
  - Output is identical to defined-with-zoom_on=0.

## Test plan
- Reset release, run one frame.
  - h_sync period 800, low 96 cycles starting 3 cycles after h_cnt=656.
  - v_sync low for 1600 cycles.
  - frame_start once per 420000 cycles.
- Normal mode, RAM model returning rData = rAddr[11:0].
  - Output pixel (x=5, y=3) shows the data for address 1*320+2 = 322.
  - Each address covers a 2x2 block.
  - de and RGB align with no skew.
- Zoom on, zoom_x=100, zoom_y=50.
  - Screen pixel (0,0) reads address 50*320+100 = 16100.
  - Screen pixel (639,479) reads 169*320+259 = 54339.
  - Each address covers a 4x4 block.
- Zoom origin change mid-frame (zoom_x 10 -> 150 at v_cnt=200).
  - The current frame keeps origin 10.
  - The next frame uses 150.
- Out-of-range origin, zoom_x=300, zoom_y=200.
  - Clamped to 160/120.
  - Maximum rAddr observed is 76799.
- Assert reset_n low at h_cnt=400, v_cnt=300 for 5 cycles.
  - Outputs go to reset values immediately.
  - After release, the first de rise is 3 cycles later at pixel (0,0).
